// File: rtl/branch_target_table.sv
// Branch-target lookup table for the fetch stage: run-time writable, 1-cycle reads.
// Optional relative entries (pc + signed offset) are enabled by defining BTT_REL_EN.
module branch_target_table #(
    parameter int D     = 10,
    parameter int A     = 5,
    parameter int DEPTH = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         wr_rel,
    input  logic         rd_en,
    input  logic [A-1:0] rd_addr,
    input  logic [D-1:0] pc,
    output logic [D-1:0] target,
    output logic         hit,
    output logic         rd_valid,
    output logic         ready
);

    localparam int         IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [A:0] LIMIT = (A+1)'(DEPTH);
    localparam logic [A-1:0] LAST = A'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t       state, state_nxt;
    logic [A-1:0] cnt, cnt_nxt;

    logic [D-1:0] mem_data  [DEPTH];
    logic         mem_valid [DEPTH];

    logic          wr_ok, rd_in, byp;
    logic [IW-1:0] wi, ri, ci;
    logic          ent_valid, ent_rel;
    logic [D-1:0]  ent_data, resolved;

    assign ready = (state == READY);
    assign wi    = wr_addr[IW-1:0];
    assign ri    = rd_addr[IW-1:0];
    assign ci    = cnt[IW-1:0];
    assign wr_ok = ready && wr_en && ({1'b0, wr_addr} < LIMIT);
    assign rd_in = ({1'b0, rd_addr} < LIMIT);
    assign byp   = wr_ok && (wr_addr == rd_addr);

`ifdef BTT_REL_EN
    logic mem_rel [DEPTH];

    // Per-entry relative flag; cleared during init like the rest of the entry
    always_ff @(posedge Clk) begin
        if (state == INIT)
            mem_rel[ci] <= 1'b0;
        else if (wr_ok)
            mem_rel[wi] <= wr_rel;
    end

    assign ent_rel = byp ? wr_rel : mem_rel[ri];
`else
    logic unused_ok;
    assign unused_ok = ^{pc, wr_rel};
    assign ent_rel   = 1'b0;
`endif

    // FSM state and init counter registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: sweep every entry once, then serve requests forever
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            INIT: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST)
                    state_nxt = READY;
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Entry storage: init sweep clears entries, afterwards accepts writes
    always_ff @(posedge Clk) begin
        if (state == INIT) begin
            mem_valid[ci] <= 1'b0;
            mem_data[ci]  <= '0;
        end else if (wr_ok) begin
            mem_valid[wi] <= 1'b1;
            mem_data[wi]  <= wr_data;
        end
    end

    // Entry selection with write-first bypass, then resolution
    always_comb begin
        ent_valid = byp ? 1'b1 : mem_valid[ri];
        ent_data  = byp ? wr_data : mem_data[ri];
        // Sign extension is a no-op modulo 2^D, so a plain D-bit add wraps correctly
        resolved  = ent_rel ? (pc + ent_data) : ent_data;
    end

    // Registered lookup outputs; hold target/hit when no read is issued
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            target   <= '0;
            hit      <= 1'b0;
            rd_valid <= 1'b0;
        end else if (ready && rd_en) begin
            rd_valid <= 1'b1;
            hit      <= rd_in && ent_valid;
            target   <= (rd_in && ent_valid) ? resolved : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: doc/branch_target_table.md
# branch_target_table

Programmable, registered branch-target lookup for the 9-bit processor's fetch stage; replaces the fixed hard-coded target table. Targets are written at run time through a write port (boot loader or test bench), validated per entry, and read with one cycle of latency alongside a hit flag. An optional relative mode turns stored entries into signed offsets from the current PC.

## Interface
- `D`, 10: target / PC width in bits
- `A`, 5: index width in bits
- `DEPTH`, 32: number of entries; must be ≤ 2^A
- `Clk` in 1: clock, all state updates on rising edge
- `Reset` in 1: asynchronous, active-high reset
- `wr_en` in 1: write strobe
- `wr_addr` in A: entry to write
- `wr_data` in D: absolute target, or signed offset when `wr_rel`=1
- `wr_rel` in 1: marks entry as relative (stored only with BTT_REL_EN)
- `rd_en` in 1: lookup strobe
- `rd_addr` in A: entry to look up
- `pc` in D: base for relative entries, sampled with `rd_en`
- `target` out D: registered lookup result
- `hit` out 1: registered; entry was valid
- `rd_valid` out 1: registered; `target`/`hit` updated this cycle
- `ready` out 1: table initialised, accepting reads/writes

## Operation
- Storage: DEPTH entries × {valid, rel, data[D-1:0]}; entry storage itself has no reset.
- FSM states: INIT, READY.
  - `Reset` asserted: state→INIT, init counter→0, `target`=0, `hit`=0, `rd_valid`=0, `ready`=0, immediately (asynchronous).
  - INIT: each cycle clears entry[counter] (valid=0, rel=0, data=0) and increments; on counter = DEPTH-1 → READY. `wr_en`/`rd_en` ignored; `rd_valid` stays 0.
  - READY: `ready`=1; stays until `Reset`.
- Write (READY, `wr_en`=1, `wr_addr` < DEPTH): entry ← {1, `wr_rel`, `wr_data`}. `wr_addr` ≥ DEPTH: write dropped, no state change.
- Read (READY, `rd_en`=1): next cycle `rd_valid`=1; if `rd_addr` < DEPTH and entry valid → `hit`=1, `target`=resolved value; otherwise `hit`=0, `target`=0.
- Resolution: rel=0 → data; rel=1 → (`pc` + sign-extended data) mod 2^D (wrap, no saturation, no flag).
- `rd_en`=0: `rd_valid`=0; `target` and `hit` hold previous values.
- Simultaneous read and write to the same in-range address: write-first bypass; read returns the newly written value, `hit`=1.
- Rewriting a valid entry overwrites it; entries cannot be individually invalidated (only `Reset` clears).

## Timing
- Read latency: 1 cycle (`rd_en` at edge N → outputs valid after edge N+1).
- Back-to-back reads every cycle supported; write throughput 1/cycle.
- Init: after `Reset` release, `ready` rises after exactly DEPTH rising edges (32 by default).
- Reset mid-read: pending result discarded; outputs 0 asynchronously.

## Configuration
- `BTT_REL_EN` defined: rel bit stored per entry; relative resolution as above.
- Not defined: no rel storage, `wr_rel` ignored, all entries absolute; `pc` unused.

## Test plan
- Reset release, then `rd_en` at addr 0 each cycle → `ready`=0 and `rd_valid`=0 for 32 cycles; then `ready`=1, first read gives `hit`=0, `target`=0.
- Write addr 1 = 19, addr 18 = 264; read 1, 18, 2 back-to-back → (19, hit 1), (264, hit 1), (0, hit 0) on consecutive cycles.
- Same-cycle write addr 5 = 59 and read addr 5 → next cycle `target`=59, `hit`=1.
- With BTT_REL_EN: write addr 3 = 0x3FE rel; read with `pc`=100 → 98; write addr 4 = 3 rel, read with `pc`=1023 → 2 (wrap). Without macro: same sequence → 0x3FE and 3.
- Write to addr 40 with DEPTH=32, A=6 → dropped; read addr 40 → `hit`=0, `target`=0.
- Assert `Reset` during READY after reads → outputs 0 immediately; earlier entries read as miss after re-init.
